// File: rtl/maze_store.sv
// rtl/maze_store.sv - wall/visited maze memory: row loader, solver read/mark port, visited-cell dump
// Optional MAZE_VISIT_COUNT_EN adds visit_count (distinct cells marked during SOLVE).
module maze_store #(
   parameter int ADDR_W = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_valid,
   output logic                    load_ready,
   input  logic [(1<<ADDR_W)-1:0]  load_data,
   output logic                    solver_start,
   input  logic [ADDR_W-1:0]       row,
   input  logic [ADDR_W-1:0]       col,
   input  logic                    maze_oe,
   input  logic                    maze_we,
   output logic                    maze_in,
   input  logic                    done,
   output logic                    path_valid,
   input  logic                    path_ready,
   output logic [ADDR_W-1:0]       path_row,
   output logic [ADDR_W-1:0]       path_col,
`ifdef MAZE_VISIT_COUNT_EN
   output logic [2*ADDR_W:0]       visit_count,
`endif
   output logic                    dump_done
);

   localparam int DIM = 1 << ADDR_W;
   localparam int PW  = 2 * ADDR_W;

   localparam logic [1:0] LOAD     = 2'd0;
   localparam logic [1:0] SOLVE    = 2'd1;
   localparam logic [1:0] DUMP     = 2'd2;
   localparam logic [1:0] FINISHED = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic              maze_in_q, maze_in_d;
   logic              start_q, start_d;
   logic              pv_q, pv_d;
   logic              dd_q, dd_d;
   logic [ADDR_W-1:0] prow_q, prow_d, pcol_q, pcol_d;

   logic [DIM-1:0]    wall_q    [DIM];
   logic [DIM-1:0]    visited_q [DIM];

   logic              load_fire;
   logic              cur_vis, nxt_vis;
   logic [PW-1:0]     ptr_nxt;

   assign load_fire = load_valid && (state_q == LOAD);
   assign ptr_nxt   = ptr_q + 1'b1;
   assign cur_vis   = visited_q[ptr_q[PW-1:ADDR_W]][ptr_q[ADDR_W-1:0]];
   assign nxt_vis   = visited_q[ptr_nxt[PW-1:ADDR_W]][ptr_nxt[ADDR_W-1:0]];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ptr_d     = ptr_q;
      maze_in_d = maze_in_q;
      start_d   = 1'b0;
      pv_d      = pv_q;
      dd_d      = dd_q;
      prow_d    = prow_q;
      pcol_d    = pcol_q;
      case (state_q)
         LOAD: begin
            if (load_fire) begin
               cnt_d = cnt_q + 1'b1;
               if (&cnt_q) begin
                  state_d = SOLVE;
                  start_d = 1'b1;
               end
            end
         end
         SOLVE: begin
            if (maze_oe) maze_in_d = wall_q[row][col];
            if (done) begin
               state_d = DUMP;
               ptr_d   = '0;
            end
         end
         DUMP: begin
            // On a handshake, look one cell ahead so back-to-back visited cells stream without a bubble.
            if (pv_q) begin
               if (path_ready) begin
                  if (&ptr_q) begin
                     pv_d    = 1'b0;
                     dd_d    = 1'b1;
                     state_d = FINISHED;
                  end else begin
                     ptr_d  = ptr_nxt;
                     pv_d   = nxt_vis;
                     prow_d = ptr_nxt[PW-1:ADDR_W];
                     pcol_d = ptr_nxt[ADDR_W-1:0];
                  end
               end
            end else if (cur_vis) begin
               pv_d   = 1'b1;
               prow_d = ptr_q[PW-1:ADDR_W];
               pcol_d = ptr_q[ADDR_W-1:0];
            end else if (&ptr_q) begin
               dd_d    = 1'b1;
               state_d = FINISHED;
            end else begin
               ptr_d = ptr_nxt;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         cnt_q     <= '0;
         ptr_q     <= '0;
         maze_in_q <= 1'b1;
         start_q   <= 1'b0;
         pv_q      <= 1'b0;
         dd_q      <= 1'b0;
         prow_q    <= '0;
         pcol_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         maze_in_q <= maze_in_d;
         start_q   <= start_d;
         pv_q      <= pv_d;
         dd_q      <= dd_d;
         prow_q    <= prow_d;
         pcol_q    <= pcol_d;
      end
   end

   // Bitmaps carry no reset; every row is rewritten during LOAD before it is used.
   always_ff @(posedge clk) begin
      if (load_fire) begin
         wall_q[cnt_q]    <= load_data;
         visited_q[cnt_q] <= '0;
      end
      if ((state_q == SOLVE) && maze_we) visited_q[row][col] <= 1'b1;
   end

`ifdef MAZE_VISIT_COUNT_EN
   logic [2*ADDR_W:0] vcnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vcnt_q <= '0;
      end else if (state_q == LOAD) begin
         vcnt_q <= '0;
      end else if ((state_q == SOLVE) && maze_we && !visited_q[row][col]) begin
         vcnt_q <= vcnt_q + 1'b1;
      end
   end

   assign visit_count = vcnt_q;
`endif

   assign load_ready   = (state_q == LOAD);
   assign solver_start = start_q;
   assign maze_in      = maze_in_q;
   assign path_valid   = pv_q;
   assign path_row     = prow_q;
   assign path_col     = pcol_q;
   assign dump_done    = dd_q;

endmodule

// File: tb/tb_maze_store.sv
// tb/tb_maze_store.sv - directed self-checking bench for maze_store (row 5 open, all else wall)
// Exercises visit_count as well when MAZE_VISIT_COUNT_EN is defined.
module tb_maze_store;

   logic        clk;
   logic        rst;
   logic        load_valid;
   logic        load_ready;
   logic [63:0] load_data;
   logic        solver_start;
   logic [5:0]  row, col;
   logic        maze_oe, maze_we;
   logic        maze_in;
   logic        done;
   logic        path_valid;
   logic        path_ready;
   logic [5:0]  path_row, path_col;
   logic        dump_done;
`ifdef MAZE_VISIT_COUNT_EN
   logic [12:0] visit_count;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   logic [11:0] exp_cells [4];

   maze_store #(.ADDR_W(6)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .solver_start(solver_start),
      .row(row), .col(col), .maze_oe(maze_oe), .maze_we(maze_we), .maze_in(maze_in),
      .done(done),
      .path_valid(path_valid), .path_ready(path_ready),
      .path_row(path_row), .path_col(path_col),
`ifdef MAZE_VISIT_COUNT_EN
      .visit_count(visit_count),
`endif
      .dump_done(dump_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests_run++;
      assert (obs === expv) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_rows(input int first, input int n);
      for (int r = first; r < first + n; r++) begin
         load_valid = 1'b1;
         load_data  = (r == 5) ? 64'h0 : {64{1'b1}};
         step();
      end
      load_valid = 1'b0;
   endtask

   task automatic mark(input logic [5:0] r, input logic [5:0] c);
      row = r; col = c; maze_we = 1'b1;
      step();
      maze_we = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_load_ready", load_ready, 1);
      chk("rst_maze_in", maze_in, 1);
      chk("rst_solver_start", solver_start, 0);
      chk("rst_path_valid", path_valid, 0);
      chk("rst_path_rc", {path_row, path_col}, 0);
      chk("rst_dump_done", dump_done, 0);
`ifdef MAZE_VISIT_COUNT_EN
      chk("rst_visit_count", visit_count, 0);
`endif
      step();
      rst = 1'b0;
   endtask

   // mode 0: path_ready always high; mode 1: high one cycle in three
   task automatic run_dump(input int mode, input int n_exp);
      int   got;
      logic stall_v;
      logic [11:0] stall_rc;
      got = 0;
      stall_v = 1'b0;
      stall_rc = '0;
      for (int cyc = 0; cyc < 6000; cyc++) begin
         if (dump_done) break;
         path_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (stall_v) chk("stall_hold", {path_valid, path_row, path_col}, {1'b1, stall_rc});
         if (path_valid && path_ready) begin
            if (got < 4) chk("dump_cell", {path_row, path_col}, exp_cells[got]);
            got++;
         end
         stall_v  = path_valid && !path_ready;
         stall_rc = {path_row, path_col};
         step();
      end
      path_ready = 1'b0;
      chk("dump_done", dump_done, 1);
      chk("dump_count", got, n_exp);
      chk("dump_valid_low", path_valid, 0);
   endtask

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0;
      row = '0; col = '0; maze_oe = 1'b0; maze_we = 1'b0;
      done = 1'b0; path_ready = 1'b0;
      #1;
      chk("reset_load_ready", load_ready, 1);
      chk("reset_maze_in", maze_in, 1);
      chk("reset_solver_start", solver_start, 0);
      chk("reset_path_valid", path_valid, 0);
      chk("reset_dump_done", dump_done, 0);
      step(); step();
      rst = 1'b0;

      // 1: 64-beat load
      load_rows(0, 63);
      chk("load63_ready", load_ready, 1);
      chk("load63_start", solver_start, 0);
      load_rows(63, 1);
      chk("load64_ready", load_ready, 0);
      chk("load64_start", solver_start, 1);

      // 2: reads
      row = 6'd5; col = 6'd10; maze_oe = 1'b1;
      step();
      chk("start_pulse_one", solver_start, 0);
      chk("read_5_10", maze_in, 0);
      row = 6'd6;
      step();
      chk("read_6_10", maze_in, 1);
      maze_oe = 1'b0; row = 6'd5;
      step();
      chk("read_hold", maze_in, 1);

      // 3: oe+we together, wall unchanged, mark visible in dump
      row = 6'd5; col = 6'd3; maze_oe = 1'b1; maze_we = 1'b1;
      step();
      chk("oewe_5_3", maze_in, 0);
      maze_we = 1'b0; row = 6'd6; col = 6'd0;
      step();
      chk("read_6_0", maze_in, 1);
      row = 6'd5; col = 6'd3;
      step();
      chk("reread_5_3", maze_in, 0);
      maze_oe = 1'b0; done = 1'b1;
      step();
      exp_cells[0] = {6'd5, 6'd3};
      run_dump(0, 1);
      done = 1'b0;

      // 4: three marks, free-flowing dump
      pulse_reset();
      load_rows(0, 64);
      mark(6'd5, 6'd1); mark(6'd5, 6'd2); mark(6'd5, 6'd63);
      done = 1'b1;
      step();
      exp_cells[0] = {6'd5, 6'd1};
      exp_cells[1] = {6'd5, 6'd2};
      exp_cells[2] = {6'd5, 6'd63};
      run_dump(0, 3);
      done = 1'b0;

      // 5: same with back-pressure
      pulse_reset();
      load_rows(0, 64);
      mark(6'd5, 6'd1); mark(6'd5, 6'd2); mark(6'd5, 6'd63);
      done = 1'b1;
      step();
      run_dump(1, 3);
      done = 1'b0;

      // 6: reset mid-DUMP and mid-LOAD
      pulse_reset();
      load_rows(0, 64);
      mark(6'd5, 6'd1); mark(6'd5, 6'd2); mark(6'd5, 6'd1); mark(6'd5, 6'd3);
`ifdef MAZE_VISIT_COUNT_EN
      chk("visit_count", visit_count, 3);
`endif
      done = 1'b1;
      step();
      for (int i = 0; i < 1000; i++) begin
         if (path_valid) break;
         step();
      end
      chk("middump_valid", {path_valid, path_row, path_col}, {1'b1, 6'd5, 6'd1});
      done = 1'b0;
      pulse_reset();
      load_rows(0, 20);
      chk("midload_ready", load_ready, 1);
      pulse_reset();
      load_rows(0, 63);
      chk("reload63_ready", load_ready, 1);
      chk("reload63_start", solver_start, 0);
      load_rows(63, 1);
      chk("reload64_start", solver_start, 1);
      chk("reload64_ready", load_ready, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
